// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave arbiter for the shared 16-bit memory bus.
// Master 0 (VGA fetch, read-only) has priority. Master 1 (UART, read/write) is
// guaranteed a grant after at most M0_BURST consecutive m0 grants while it waits.
// Grants are registered and atomic. Each master gets its own ack and read data.
// Optional feature macro: ARB_TIMEOUT_EN. When defined, a grant the slave never
// acks is aborted after TIMEOUT_CYCLES cycles. The master then gets an ack with
// zero data, and o_timeout pulses. Without the macro, grants wait indefinitely
// and o_timeout is tied low.
module bus_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int M0_BURST       = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  // master 0: read-only, high priority
  input  logic              i_m0_cs,
  input  logic [ADDR_W-1:0] i_m0_addr,
  output logic [DATA_W-1:0] o_m0_dat,
  output logic              o_m0_ack,
  // master 1: read/write, low priority with guaranteed service
  input  logic              i_m1_cs,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_dat,
  output logic [DATA_W-1:0] o_m1_dat,
  output logic              o_m1_ack,
  // shared slave bus
  output logic              o_cs,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_dat,
  input  logic [DATA_W-1:0] i_dat,
  input  logic              i_ack,
  // status
  output logic [1:0]        o_grant,
  output logic              o_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // The burst limit is at most 15, so a 4-bit counter always holds it.
  localparam logic [3:0] BURST_LIMIT = 4'(M0_BURST);

  state_t     state;
  logic [3:0] burst_cnt;
  logic [3:0] burst_next;
  logic       m0_wins;

  // m0 wins the IDLE decision unless m1 is also waiting and m0 has used its burst
  assign m0_wins = i_m0_cs && (!i_m1_cs || (burst_cnt < BURST_LIMIT));

  // Count of consecutive m0 grants taken while m1 waits, saturating at the limit
  assign burst_next = (burst_cnt >= BURST_LIMIT) ? BURST_LIMIT : burst_cnt + 4'd1;

`ifdef ARB_TIMEOUT_EN
  localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_expired;

  // The grant is abandoned once the wait counter reaches the limit
  assign tmo_expired = (tmo_cnt == TMO_LIMIT);
`else
  // TIMEOUT_CYCLES has no effect in this build. Grants wait for i_ack forever.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);

  // Without the watchdog, the abort pulse is constant zero
  assign o_timeout = 1'b0;
`endif

  // Arbiter FSM. Every bus and response output is registered here.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      burst_cnt <= 4'd0;
      o_cs      <= 1'b0;
      o_we      <= 1'b0;
      o_addr    <= '0;
      o_dat     <= '0;
      o_grant   <= 2'b00;
      o_m0_dat  <= '0;
      o_m0_ack  <= 1'b0;
      o_m1_dat  <= '0;
      o_m1_ack  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
      o_timeout <= 1'b0;
`endif
    end else begin
      o_m0_ack <= 1'b0;
      o_m1_ack <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      o_timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (m0_wins) begin
            state   <= GNT0;
            o_cs    <= 1'b1;
            o_we    <= 1'b0;
            o_addr  <= i_m0_addr;
            o_grant <= 2'b01;
            if (i_m1_cs) begin
              burst_cnt <= burst_next;
            end else begin
              burst_cnt <= 4'd0;
            end
`ifdef ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end else if (i_m1_cs) begin
            state     <= GNT1;
            o_cs      <= 1'b1;
            o_we      <= i_m1_we;
            o_addr    <= i_m1_addr;
            o_dat     <= i_m1_dat;
            o_grant   <= 2'b10;
            burst_cnt <= 4'd0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end

        GNT0: begin
          if (i_ack) begin
            state    <= IDLE;
            o_cs     <= 1'b0;
            o_we     <= 1'b0;
            o_grant  <= 2'b00;
            o_m0_dat <= i_dat;
            o_m0_ack <= 1'b1;
`ifdef ARB_TIMEOUT_EN
          end else if (tmo_expired) begin
            state     <= IDLE;
            o_cs      <= 1'b0;
            o_we      <= 1'b0;
            o_grant   <= 2'b00;
            o_m0_dat  <= '0;
            o_m0_ack  <= 1'b1;
            o_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end

        GNT1: begin
          if (i_ack) begin
            state    <= IDLE;
            o_cs     <= 1'b0;
            o_we     <= 1'b0;
            o_grant  <= 2'b00;
            o_m1_dat <= i_dat;
            o_m1_ack <= 1'b1;
`ifdef ARB_TIMEOUT_EN
          end else if (tmo_expired) begin
            state     <= IDLE;
            o_cs      <= 1'b0;
            o_we      <= 1'b0;
            o_grant   <= 2'b00;
            o_m1_dat  <= '0;
            o_m1_ack  <= 1'b1;
            o_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end

        default: begin
          state   <= IDLE;
          o_cs    <= 1'b0;
          o_we    <= 1'b0;
          o_grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed stimulus for bus_arbiter. A transaction-level model
// of the arbitration rules predicts every output on every cycle. Hand-computed
// literal expectations pin the scenarios that the model itself must reproduce.
// The timeout scenario is included when ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;

  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 16;
  localparam int M0_BURST       = 4;
  localparam int TIMEOUT_CYCLES = 16;

`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              m0_cs = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic              m1_cs = 1'b0;
  logic              m1_we = 1'b0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [DATA_W-1:0] m1_dat = '0;
  logic [DATA_W-1:0] s_dat = '0;
  logic              s_ack = 1'b0;

  logic [DATA_W-1:0] o_m0_dat, o_m1_dat, o_dat;
  logic [ADDR_W-1:0] o_addr;
  logic              o_m0_ack, o_m1_ack, o_cs, o_we, o_timeout;
  logic [1:0]        o_grant;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .M0_BURST(M0_BURST), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m0_cs(m0_cs), .i_m0_addr(m0_addr), .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack),
    .i_m1_cs(m1_cs), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_dat(m1_dat),
    .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack),
    .o_cs(o_cs), .o_we(o_we), .o_addr(o_addr), .o_dat(o_dat), .i_dat(s_dat), .i_ack(s_ack),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  // ---------------- comparison helper ----------------
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic c0, input logic [15:0] a0, input logic c1,
                               input logic we1, input logic [15:0] a1, input logic [15:0] d1);
    m0_cs = c0; m0_addr = a0; m1_cs = c1; m1_we = we1; m1_addr = a1; m1_dat = d1;
  endtask

  task automatic applySlave(input logic ack, input logic [15:0] dat);
    s_ack = ack; s_dat = dat;
  endtask

  task automatic nextCycle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- transaction-level model ----------------
  // The bus carries at most one transaction. It is recorded when the grant is made.
  typedef struct {
    bit          busy;
    int          owner;
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdat;
    int          age;
  } txn_t;

  txn_t        cur;
  bit          grant_hist[$];
  logic [15:0] m0_rdata = '0;
  logic [15:0] m1_rdata = '0;
  bit          m0_ack_exp = 0;
  bit          m1_ack_exp = 0;
  bit          tmo_exp = 0;

  // Counts how many of the most recent grants went to m0 while m1 was waiting.
  function automatic int m0Streak();
    int n = 0;
    for (int i = grant_hist.size() - 1; i >= 0; i--) begin
      if (!grant_hist[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [1:0] grantExp();
    if (!cur.busy) return 2'b00;
    return (cur.owner == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic modelStep();
    m0_ack_exp = 0; m1_ack_exp = 0; tmo_exp = 0;
    if (!rst_n) begin
      cur.busy = 0; cur.owner = 0; cur.addr = '0; cur.we = 0; cur.wdat = '0; cur.age = 0;
      grant_hist.delete();
      m0_rdata = '0; m1_rdata = '0;
      return;
    end
    if (cur.busy) begin
      cur.age++;
      if (s_ack) begin
        if (cur.owner == 0) begin m0_ack_exp = 1; m0_rdata = s_dat; end
        else begin m1_ack_exp = 1; m1_rdata = s_dat; end
        cur.busy = 0;
      end else if (TMO_EN && cur.age == TIMEOUT_CYCLES + 1) begin
        if (cur.owner == 0) begin m0_ack_exp = 1; m0_rdata = '0; end
        else begin m1_ack_exp = 1; m1_rdata = '0; end
        tmo_exp  = 1;
        cur.busy = 0;
      end
    end else if (m0_cs && !(m1_cs && m0Streak() >= M0_BURST)) begin
      cur.busy = 1; cur.owner = 0; cur.addr = m0_addr; cur.we = 0; cur.age = 0;
      grant_hist.push_back(m1_cs);
    end else if (m1_cs) begin
      cur.busy = 1; cur.owner = 1; cur.addr = m1_addr; cur.we = m1_we; cur.wdat = m1_dat; cur.age = 0;
      grant_hist.push_back(1'b0);
    end
    if (grant_hist.size() > 32) void'(grant_hist.pop_front());
  endtask

  // Model advance on each active edge, then compare the settled outputs
  always @(posedge clk) begin
    modelStep();
    #1;
    checkOutput("cs", o_cs, cur.busy);
    checkOutput("grant", o_grant, grantExp());
    checkOutput("m0_ack", o_m0_ack, m0_ack_exp);
    checkOutput("m1_ack", o_m1_ack, m1_ack_exp);
    checkOutput("m0_dat", o_m0_dat, m0_rdata);
    checkOutput("m1_dat", o_m1_dat, m1_rdata);
    checkOutput("timeout", o_timeout, tmo_exp);
    if (cur.busy) begin
      checkOutput("we", o_we, cur.we);
      checkOutput("addr", o_addr, cur.addr);
      if (cur.we) checkOutput("wdat", o_dat, cur.wdat);
    end
  end

  // ---------------- directed scenarios ----------------
  int grant_log[$];
  int grant_at[$];
  int exp_seq[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

  initial begin
    #1 rst_n = 1'b0;
    nextCycle(2);
    // reset state
    checkOutput("rst_cs", o_cs, 0);
    checkOutput("rst_grant", o_grant, 0);
    checkOutput("rst_acks", {o_m0_ack, o_m1_ack, o_timeout}, 0);
    checkOutput("rst_dat", {o_m0_dat, o_m1_dat}, 0);
    // i_ack in IDLE is ignored
    rst_n = 1'b1;
    applySlave(1'b1, 16'hFFFF);
    nextCycle(1);
    checkOutput("idle_ack_ignored", {o_m0_ack, o_m1_ack, o_cs}, 0);
    checkOutput("idle_ack_no_dat", o_m0_dat, 16'h0000);
    applySlave(1'b0, 16'h0000);
    nextCycle(1);

    $display("[TB] single m0 read");
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000);
    nextCycle(1);
    checkOutput("m0_cs_latency", o_cs, 1);
    checkOutput("m0_grant", o_grant, 2'b01);
    checkOutput("m0_we", o_we, 0);
    checkOutput("m0_addr", o_addr, 16'h1234);
    nextCycle(1);
    checkOutput("m0_wait_noack", o_m0_ack, 0);
    checkOutput("m0_wait_grant", o_grant, 2'b01);
    applySlave(1'b1, 16'hBEEF);
    nextCycle(1);
    checkOutput("m0_ack_pulse", o_m0_ack, 1);
    checkOutput("m0_rdata", o_m0_dat, 16'hBEEF);
    applySlave(1'b0, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    nextCycle(1);
    checkOutput("m0_ack_single", o_m0_ack, 0);
    checkOutput("m0_rdata_hold", o_m0_dat, 16'hBEEF);

    $display("[TB] m1 write");
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFF0, 16'h00A5);
    nextCycle(1);
    checkOutput("m1_grant", o_grant, 2'b10);
    checkOutput("m1_we", o_we, 1);
    checkOutput("m1_addr", o_addr, 16'hFFF0);
    checkOutput("m1_wdat", o_dat, 16'h00A5);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h1111, 16'h2222);
    applySlave(1'b1, 16'h5A5A);
    nextCycle(1);
    checkOutput("m1_ack_pulse", o_m1_ack, 1);
    checkOutput("m1_m0_ack_quiet", o_m0_ack, 0);
    checkOutput("m1_rdata_on_write", o_m1_dat, 16'h5A5A);
    applySlave(1'b0, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    nextCycle(2);

    $display("[TB] both masters continuous");
    rst_n = 1'b0;
    nextCycle(1);
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0200, 16'h0000);
    for (int cyc = 0; cyc < 22; cyc++) begin
      @(negedge clk);
      if (o_grant != 2'b00) begin
        grant_log.push_back(int'(o_grant));
        grant_at.push_back(cyc);
      end
      applySlave(o_cs, 16'(cyc + 16'h0C00));
    end
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    nextCycle(2);
    applySlave(1'b0, 16'h0000);
    nextCycle(1);
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("grant_seq[%0d]", i), (i < grant_log.size()) ? grant_log[i] : 0, exp_seq[i]);
    checkOutput("grant_gap", (grant_at.size() > 1) ? grant_at[1] - grant_at[0] : 0, 2);

    $display("[TB] m1 busy while m0 arrives");
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0042, 16'h1111);
    nextCycle(1);
    checkOutput("m1_hold_grant", o_grant, 2'b10);
    applyStimulus(1'b1, 16'h0777, 1'b1, 1'b0, 16'hDEAD, 16'h9999);
    nextCycle(3);
    checkOutput("m1_not_preempted", o_grant, 2'b10);
    checkOutput("m1_addr_latched", o_addr, 16'h0042);
    checkOutput("m1_dat_latched", o_dat, 16'h1111);
    applySlave(1'b1, 16'h2222);
    nextCycle(1);
    checkOutput("m1_done_ack", o_m1_ack, 1);
    checkOutput("m1_done_dat", o_m1_dat, 16'h2222);
    checkOutput("m1_done_dead", o_grant, 2'b00);
    applySlave(1'b0, 16'h0000);
    applyStimulus(1'b1, 16'h0777, 1'b0, 1'b0, 16'h0000, 16'h0000);
    nextCycle(1);
    checkOutput("m0_after_m1", o_grant, 2'b01);
    checkOutput("m0_after_m1_addr", o_addr, 16'h0777);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    nextCycle(1);
    checkOutput("m0_atomic_hold", o_grant, 2'b01);
    applySlave(1'b1, 16'h3333);
    nextCycle(1);
    checkOutput("m0_atomic_ack", o_m0_ack, 1);
    checkOutput("m0_atomic_dat", o_m0_dat, 16'h3333);
    applySlave(1'b0, 16'h0000);
    nextCycle(1);

    $display("[TB] reset mid GNT1");
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0ABC, 16'h0000);
    nextCycle(1);
    checkOutput("pre_rst_cs", {o_cs, o_grant}, 3'b110);
    applyStimulus(1'b1, 16'h0999, 1'b1, 1'b0, 16'h0ABC, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_cs", {o_cs, o_we, o_grant}, 0);
    checkOutput("async_rst_dat", {o_m0_dat, o_m1_dat}, 0);
    checkOutput("async_rst_addr", o_addr, 0);
    nextCycle(1);
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'h0999, 1'b0, 1'b0, 16'h0000, 16'h0000);
    nextCycle(1);
    checkOutput("post_rst_grant", o_grant, 2'b01);
    checkOutput("post_rst_addr", o_addr, 16'h0999);
    applySlave(1'b1, 16'h4444);
    nextCycle(1);
    checkOutput("post_rst_ack", o_m0_ack, 1);
    checkOutput("post_rst_dat", o_m0_dat, 16'h4444);
    applySlave(1'b0, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    nextCycle(2);

`ifdef ARB_TIMEOUT_EN
    $display("[TB] timeout on silent slave");
    applyStimulus(1'b1, 16'h0055, 1'b0, 1'b0, 16'h0000, 16'h0000);
    nextCycle(1);
    checkOutput("tmo_cs", o_cs, 1);
    for (int j = 1; j <= 17; j++) begin
      nextCycle(1);
      checkOutput($sformatf("tmo_pulse[%0d]", j), o_timeout, (j == 17) ? 1 : 0);
    end
    checkOutput("tmo_ack", o_m0_ack, 1);
    checkOutput("tmo_dat", o_m0_dat, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0066, 16'h0000);
    nextCycle(1);
    checkOutput("tmo_after_single", o_timeout, 0);
    nextCycle(1);
    checkOutput("tmo_next_grant", o_grant, 2'b10);
    applySlave(1'b1, 16'h7777);
    nextCycle(1);
    checkOutput("tmo_next_ack", o_m1_ack, 1);
    checkOutput("tmo_next_dat", o_m1_dat, 16'h7777);
    applySlave(1'b0, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    nextCycle(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
